// File: rtl/fp_addsub_seq_pkg.sv
// fp_addsub_seq_pkg
//   Shared definitions for the multi-cycle binary32 add/sub sequencer:
//   field widths, the datapath width used around the shared adder,
//   the default canonical NaN, exception bit positions and the FSM states.
package fp_addsub_seq_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int SIG_W = MAN_W + 1;   // significand with hidden bit
    localparam int SUM_W = SIG_W + 1;   // significand sum with carry bit

    localparam logic [EXP_W-1:0] EXP_MAX = '1;
    localparam logic [31:0]      QNAN_DEFAULT = 32'h7FC0_0000;

    // exc = {invalid, overflow, underflow}
    localparam int EXC_INVALID   = 2;
    localparam int EXC_OVERFLOW  = 1;
    localparam int EXC_UNDERFLOW = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UNPACK,
        ST_EXPD,
        ST_ALIGN,
        ST_MADD,
        ST_MNEG,
        ST_NORM,
        ST_DONE
    } state_e;

endpackage

// File: rtl/fp_addsub_seq_adder.sv
// adder_26bit
//   Plain 26-bit ripple/inferred adder shared by the add/sub sequencer.
//   in1, in2 : addends
//   s        : 26-bit sum
//   cout     : carry out of bit 25
module adder_26bit (
    input  logic [25:0] in1,
    input  logic [25:0] in2,
    output logic [25:0] s,
    output logic        cout
);

    assign {cout, s} = {1'b0, in1} + {1'b0, in2};

endmodule

// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq
//   Multi-cycle IEEE754 binary32 add/subtract. One adder_26bit instance is
//   time-multiplexed for exponent difference, significand add/sub and
//   negation. Denormal inputs are flushed to zero; alignment truncates.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : operand handshake (in_ready only when idle)
//   op                  : 0 = a+b, 1 = a-b
//   a, b                : binary32 operands
//   out_valid/out_ready : result handshake
//   result              : binary32 result
//   exc                 : {invalid, overflow, underflow}, valid with out_valid
module fp_addsub_seq
    import fp_addsub_seq_pkg::*;
#(
    parameter logic [31:0] QNAN    = QNAN_DEFAULT,
    parameter int          MAX_LAT = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [2:0]  exc
);

    state_e state_q, state_d;

    // Operand registers; sb holds the effective sign of b (op folded in).
    logic             sa_q, sa_d, sb_q, sb_d;
    logic [EXP_W-1:0] ea_q, ea_d, eb_q, eb_d;
    logic [SIG_W-1:0] ma_q, ma_d, mb_q, mb_d;
    logic [EXP_W-1:0] d_q, d_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic             sign_q, sign_d;
    logic [31:0]      result_q, result_d;
    logic [2:0]       exc_q, exc_d;
    logic [5:0]       lat_q, lat_d;

    // Shared adder: in1={x,1}, in2={y,cin} yields x+y+cin in s[25:1].
    logic [SUM_W-1:0] add_x, add_y, add_sum;
    logic             add_cin, add_cout;
    logic [25:0]      add_s;

    adder_26bit u_adder (
        .in1  ({add_x, 1'b1}),
        .in2  ({add_y, add_cin}),
        .s    (add_s),
        .cout (add_cout)
    );

    assign add_sum = add_s[25:1];

    logic eff_sub;
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

    // Swapping exchanges sign/exponent/significand together, so the xor
    // of the two effective signs is invariant.
    assign eff_sub = sa_q ^ sb_q;

    assign a_nan  = (ea_q == EXP_MAX) && (ma_q[MAN_W-1:0] != '0);
    assign b_nan  = (eb_q == EXP_MAX) && (mb_q[MAN_W-1:0] != '0);
    assign a_inf  = (ea_q == EXP_MAX) && (ma_q[MAN_W-1:0] == '0);
    assign b_inf  = (eb_q == EXP_MAX) && (mb_q[MAN_W-1:0] == '0);
    assign a_zero = (ea_q == '0);
    assign b_zero = (eb_q == '0);

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        ea_d     = ea_q;
        eb_d     = eb_q;
        ma_d     = ma_q;
        mb_d     = mb_q;
        d_d      = d_q;
        sum_d    = sum_q;
        sign_d   = sign_q;
        result_d = result_q;
        exc_d    = exc_q;
        lat_d    = lat_q;
        add_x    = '0;
        add_y    = '0;
        add_cin  = 1'b0;

        if ((state_q != ST_IDLE) && (state_q != ST_DONE) && (lat_q != '1)) begin
            lat_d = lat_q + 6'd1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sa_d    = a[31];
                    ea_d    = a[30:23];
                    ma_d    = {1'b1, a[22:0]};
                    sb_d    = b[31] ^ op;
                    eb_d    = b[30:23];
                    mb_d    = {1'b1, b[22:0]};
                    lat_d   = '0;
                    state_d = ST_UNPACK;
                end
            end

            ST_UNPACK: begin
                exc_d   = '0;
                state_d = ST_DONE;
                if (a_nan || b_nan) begin
                    result_d           = QNAN;
                    exc_d[EXC_INVALID] = 1'b1;
                end else if (a_inf && b_inf) begin
                    if (eff_sub) begin
                        result_d           = QNAN;
                        exc_d[EXC_INVALID] = 1'b1;
                    end else begin
                        result_d = {sa_q, EXP_MAX, {MAN_W{1'b0}}};
                    end
                end else if (a_inf) begin
                    result_d = {sa_q, EXP_MAX, {MAN_W{1'b0}}};
                end else if (b_inf) begin
                    result_d = {sb_q, EXP_MAX, {MAN_W{1'b0}}};
                end else if (a_zero && b_zero) begin
                    result_d = {sa_q & sb_q, 31'd0};
                end else if (b_zero) begin
                    result_d = {sa_q, ea_q, ma_q[MAN_W-1:0]};
                end else if (a_zero) begin
                    result_d = {sb_q, eb_q, mb_q[MAN_W-1:0]};
                end else begin
                    state_d = ST_EXPD;
                end
            end

            ST_EXPD: begin
                add_x   = {{(SUM_W-EXP_W){1'b0}}, ea_q};
                add_y   = ~{{(SUM_W-EXP_W){1'b0}}, eb_q};
                add_cin = 1'b1;
                // No carry out means ea < eb: swap and recompute once.
                if (!add_cout) begin
                    sa_d = sb_q;
                    sb_d = sa_q;
                    ea_d = eb_q;
                    eb_d = ea_q;
                    ma_d = mb_q;
                    mb_d = ma_q;
                end else begin
                    d_d     = add_sum[EXP_W-1:0];
                    state_d = ST_ALIGN;
                end
            end

            ST_ALIGN: begin
                mb_d    = (d_q >= 8'd25) ? '0 : (mb_q >> d_q);
                sign_d  = sa_q;
                state_d = ST_MADD;
            end

            ST_MADD: begin
                add_x = {1'b0, ma_q};
                if (eff_sub) begin
                    add_y   = ~{1'b0, mb_q};
                    add_cin = 1'b1;
                end else begin
                    add_y   = {1'b0, mb_q};
                end
                sum_d   = add_sum;
                state_d = (eff_sub && !add_cout) ? ST_MNEG : ST_NORM;
            end

            ST_MNEG: begin
                add_x   = '0;
                add_y   = ~sum_q;
                add_cin = 1'b1;
                sum_d   = add_sum;
                sign_d  = ~sign_q;
                state_d = ST_NORM;
            end

            ST_NORM: begin
                // ea_q doubles as the result exponent counter here.
                if (sum_q == '0) begin
                    result_d = '0;
                    exc_d    = '0;
                    state_d  = ST_DONE;
                end else if (sum_q[SUM_W-1]) begin
                    if (ea_q == (EXP_MAX - 8'd1)) begin
                        result_d            = {sign_q, EXP_MAX, {MAN_W{1'b0}}};
                        exc_d               = '0;
                        exc_d[EXC_OVERFLOW] = 1'b1;
                        state_d             = ST_DONE;
                    end else begin
                        sum_d = sum_q >> 1;
                        ea_d  = ea_q + 8'd1;
                    end
                end else if (!sum_q[SIG_W-1]) begin
                    if (ea_q == 8'd1) begin
                        result_d             = {sign_q, 31'd0};
                        exc_d                = '0;
                        exc_d[EXC_UNDERFLOW] = 1'b1;
                        state_d              = ST_DONE;
                    end else begin
                        sum_d = sum_q << 1;
                        ea_d  = ea_q - 8'd1;
                    end
                end else begin
                    result_d = {sign_q, ea_q, sum_q[MAN_W-1:0]};
                    exc_d    = '0;
                    state_d  = ST_DONE;
                end
            end

            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            ea_q     <= '0;
            eb_q     <= '0;
            ma_q     <= '0;
            mb_q     <= '0;
            d_q      <= '0;
            sum_q    <= '0;
            sign_q   <= 1'b0;
            result_q <= '0;
            exc_q    <= '0;
            lat_q    <= '0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            ea_q     <= ea_d;
            eb_q     <= eb_d;
            ma_q     <= ma_d;
            mb_q     <= mb_d;
            d_q      <= d_d;
            sum_q    <= sum_d;
            sign_q   <= sign_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            lat_q    <= lat_d;
        end
    end

    // Busy-cycle bound and adder carry-injection sanity.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (int'(lat_q) < MAX_LAT);
            assert (add_s[0] == ~add_cin);
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign exc       = exc_q;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// tb_fp_addsub_seq
//   Directed self-checking bench for fp_addsub_seq with hand-computed
//   binary32 results, exception flags, latency, handshake and reset cases.
module tb_fp_addsub_seq;

    localparam int MAX_LAT = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [2:0]  exc;

    int checks   = 0;
    int failures = 0;

    fp_addsub_seq #(
        .QNAN    (32'h7FC0_0000),
        .MAX_LAT (MAX_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .exc       (exc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input string what,
                         input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s.%s: got %h, expected %h", tag, what, got, exp);
        end
    endtask

    // exp_lat > 0: exact accept-to-out_valid count; 0: only the MAX_LAT bound.
    task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                          input logic top, input logic [31:0] er, input logic [2:0] ee,
                          input int exp_lat, input int hold);
        int n;
        @(negedge clk);
        check(tag, "in_ready", {31'd0, in_ready}, 32'd1);
        a        = ta;
        b        = tb;
        op       = top;
        in_valid = 1'b1;
        @(posedge clk);
        n = 1;
        #1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        while (out_valid !== 1'b1 && n < 64) begin
            @(posedge clk);
            n++;
            #1;
        end
        if (exp_lat > 0) begin
            check(tag, "latency", n, exp_lat);
        end else begin
            check(tag, "latency_bound", {31'd0, (n <= MAX_LAT)}, 32'd1);
        end
        check(tag, "result", result, er);
        check(tag, "exc", {29'd0, exc}, {29'd0, ee});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check(tag, "hold_valid", {31'd0, out_valid}, 32'd1);
            check(tag, "hold_in_ready", {31'd0, in_ready}, 32'd0);
            check(tag, "hold_result", result, er);
            check(tag, "hold_exc", {29'd0, exc}, {29'd0, ee});
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check(tag, "released", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 1'b0;
        a         = '0;
        b         = '0;
        #1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset", "in_ready", {31'd0, in_ready}, 32'd1);
        check("reset", "out_valid", {31'd0, out_valid}, 32'd0);
        check("reset", "result", result, 32'd0);
        check("reset", "exc", {29'd0, exc}, 32'd0);
        rst = 1'b0;

        run_op("one_plus_one",  32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 3'b000, 0, 0);
        run_op("swap_sub",      32'h3F80_0000, 32'h4000_0000, 1'b1, 32'hBF80_0000, 3'b000, 0, 0);
        run_op("cancel",        32'h3FC0_0000, 32'h3FC0_0000, 1'b1, 32'h0000_0000, 3'b000, 0, 0);
        run_op("norm23",        32'h3F80_0001, 32'h3F80_0000, 1'b1, 32'h3400_0000, 3'b000, 0, 0);
        run_op("overflow",      32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 3'b010, 0, 0);
        run_op("underflow",     32'h0080_0000, 32'h0080_0001, 1'b1, 32'h8000_0000, 3'b001, 0, 0);
        run_op("nan_a",         32'h7FC0_0000, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 3'b100, 2, 0);
        run_op("nan_b",         32'h3F80_0000, 32'h7F80_0001, 1'b0, 32'h7FC0_0000, 3'b100, 2, 0);
        run_op("inf_minus_inf", 32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000, 3'b100, 2, 0);
        run_op("far_align",     32'h3F80_0000, 32'h3080_0000, 1'b0, 32'h3F80_0000, 3'b000, 0, 0);
        run_op("handshake",     32'h3F80_0000, 32'h3FC0_0000, 1'b1, 32'hBF00_0000, 3'b000, 0, 5);
        run_op("mixed_signs",   32'h3F80_0000, 32'hBF00_0000, 1'b0, 32'h3F00_0000, 3'b000, 0, 0);
        run_op("inf_plus_one",  32'h7F80_0000, 32'h3F80_0000, 1'b0, 32'h7F80_0000, 3'b000, 2, 0);
        run_op("one_minus_inf", 32'h3F80_0000, 32'h7F80_0000, 1'b1, 32'hFF80_0000, 3'b000, 2, 0);
        run_op("negz_minus_z",  32'h8000_0000, 32'h0000_0000, 1'b1, 32'h8000_0000, 3'b000, 2, 0);
        run_op("z_minus_negz",  32'h0000_0000, 32'h8000_0000, 1'b1, 32'h0000_0000, 3'b000, 2, 0);
        run_op("zero_minus_x",  32'h0000_0000, 32'h3F80_0000, 1'b1, 32'hBF80_0000, 3'b000, 2, 0);
        run_op("x_plus_negz",   32'h4049_0FDB, 32'h8000_0000, 1'b0, 32'h4049_0FDB, 3'b000, 2, 0);
        run_op("truncate",      32'h3F80_0000, 32'h3F80_0001, 1'b0, 32'h4000_0000, 3'b000, 0, 0);
        run_op("neg_plus_neg",  32'hBF80_0000, 32'hBF80_0000, 1'b0, 32'hC000_0000, 3'b000, 0, 0);
        run_op("two_plus_three",32'h4000_0000, 32'h4040_0000, 1'b0, 32'h40A0_0000, 3'b000, 0, 0);
        run_op("denorm_ftz",    32'h0040_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 3'b000, 2, 0);

        // Reset in the middle of a long normalisation.
        @(negedge clk);
        a        = 32'h3F80_0001;
        b        = 32'h3F80_0000;
        op       = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("mid_reset", "busy", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_reset", "in_ready", {31'd0, in_ready}, 32'd1);
        check("mid_reset", "out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_reset", "result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("mid_reset", "abandoned", {31'd0, out_valid}, 32'd0);
        run_op("after_reset",   32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 3'b000, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
